// File: rtl/svi_mon_pkg.sv
// svi_mon_pkg: shared lane sizing, lane value and monitor state types
package svi_mon_pkg;
    localparam int SVI_SIZE = 8;
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int LANE_W = lane_w(SVI_SIZE);
    typedef logic [2:0] lane_val_t;
    typedef enum logic [0:0] {IDLE, PRESENT} state_e;
endpackage

// File: rtl/svi_array_monitor_if.sv
// I: scalar lane interface; modport C is the input-only observer view
interface I;
    logic x;
    logic y;
    logic z;
    modport C (input x, input y, input z);
endinterface

// File: rtl/svi_array_monitor_rr_arbiter.sv
// rr_arbiter: first requesting lane at or after ptr, wrapping, combinational
module rr_arbiter import svi_mon_pkg::*; #(
    parameter int SIZE = SVI_SIZE,
    parameter int LW   = lane_w(SIZE)
) (
    input  logic [SIZE-1:0] req,
    input  logic [LW-1:0]   ptr,
    output logic [LW-1:0]   gnt_idx,
    output logic            any_grant
);
    int j;
    // scan farthest-first so the nearest requester past ptr wins
    always_comb begin
        gnt_idx = '0;
        any_grant = 1'b0;
        j = 0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % SIZE;
            if (req[j]) begin
                gnt_idx = j[LW-1:0];
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/svi_array_monitor.sv
// svi_array_monitor: serialises per-lane value changes of an I.C array into
// a round-robin arbitrated valid/ready event stream with a saturating count
module svi_array_monitor import svi_mon_pkg::*; #(
    parameter int SIZE  = SVI_SIZE,
    parameter int CNT_W = 16,
    parameter int LW    = lane_w(SIZE)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    I.C                      p [SIZE-1:0],
    input  logic             i_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [LW-1:0]    o_lane,
    output lane_val_t        o_data,
    output logic [CNT_W-1:0] o_count
);
    lane_val_t [SIZE-1:0] cur;
    lane_val_t [SIZE-1:0] samp;
    lane_val_t [SIZE-1:0] rep;
    logic [SIZE-1:0] pend;
    logic [LW-1:0] rr_ptr;
    logic [LW-1:0] gnt_idx;
    logic any_grant;
    state_e state;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign cur[i] = {p[i].z, p[i].y, p[i].x};
        assign pend[i] = samp[i] != rep[i];
    end

    rr_arbiter #(.SIZE(SIZE), .LW(LW)) u_arb (
        .req(pend),
        .ptr(rr_ptr),
        .gnt_idx(gnt_idx),
        .any_grant(any_grant)
    );

    // rep only moves on accept, so a lane edited mid-presentation re-pends
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            samp <= '0;
            rep <= '0;
            rr_ptr <= '0;
            state <= IDLE;
            o_valid <= 1'b0;
            o_lane <= '0;
            o_data <= '0;
            o_count <= '0;
        end else begin
            samp <= cur;
            if (state == IDLE) begin
                if (i_en && any_grant) begin
                    o_valid <= 1'b1;
                    o_lane <= gnt_idx;
                    o_data <= samp[gnt_idx];
                    state <= PRESENT;
                end
            end else if (i_ready) begin
                rep[o_lane] <= o_data;
                rr_ptr <= (o_lane == LW'(SIZE - 1)) ? '0 : o_lane + 1'b1;
                o_count <= (&o_count) ? o_count : o_count + 1'b1;
                o_valid <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_svi_array_monitor.sv
// tb_svi_array_monitor: directed scenario tasks with hand-computed expectations
module tb_svi_array_monitor;
    localparam int SIZE = 8;
    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_en = 1'b1;
    logic i_ready = 1'b1;
    logic o_valid, s_valid;
    logic [2:0] o_lane, s_lane;
    logic [2:0] o_data, s_data;
    logic [15:0] o_count;
    logic [1:0] s_count;
    logic [SIZE-1:0][2:0] drv = '0;
    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    I u_I [SIZE-1:0] ();
    for (genvar g = 0; g < SIZE; g++) begin : g_drv
        assign u_I[g].x = drv[g][0];
        assign u_I[g].y = drv[g][1];
        assign u_I[g].z = drv[g][2];
    end

    svi_array_monitor #(.SIZE(SIZE), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .p(u_I), .i_en(i_en), .o_valid(o_valid),
        .i_ready(i_ready), .o_lane(o_lane), .o_data(o_data), .o_count(o_count)
    );

    // narrow-counter twin shares all inputs to reach saturation quickly
    svi_array_monitor #(.SIZE(SIZE), .CNT_W(2)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .p(u_I), .i_en(i_en), .o_valid(s_valid),
        .i_ready(i_ready), .o_lane(s_lane), .o_data(s_data), .o_count(s_count)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        drv = '0;
        i_en = 1'b1;
        i_ready = 1'b1;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        drv = '0;
        i_ready = 1'b1;
        i_rst = 1'b1;
        #2;
        checks++;
        if ({o_valid, o_lane, o_data, o_count} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state got v=%0b l=%0d d=%0b c=%0d exp all 0", o_valid, o_lane, o_data, o_count);
        end
        step();
        i_rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            seen |= o_valid;
        end
        checks++;
        if (seen !== 1'b0 || o_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_idle got seen_valid=%0b count=%0d exp 0 0", seen, o_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        step();
        drv[3] = 3'b001;
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got valid=%0b exp 0", o_valid);
        end
        step();
        checks++;
        if ({o_valid, o_lane, o_data} !== {1'b1, 3'd3, 3'b001}) begin
            failures++;
            $display("FAIL single_event got v=%0b l=%0d d=%0b exp 1 3 001", o_valid, o_lane, o_data);
        end
        step();
        checks++;
        if (o_valid !== 1'b0 || o_count !== 16'd1 || s_count !== 2'd1) begin
            failures++;
            $display("FAIL single_accept got v=%0b c=%0d sc=%0d exp 0 1 1", o_valid, o_count, s_count);
        end
    endtask

    task automatic test_all_lanes();
        do_reset();
        for (int k = 0; k < SIZE; k++) drv[k] = 3'b101;
        step();
        for (int k = 0; k < SIZE; k++) begin
            step();
            checks++;
            if ({o_valid, o_lane, o_data} !== {1'b1, 3'(k), 3'b101}) begin
                failures++;
                $display("FAIL all_event%0d got v=%0b l=%0d d=%0b exp 1 %0d 101", k, o_valid, o_lane, o_data, k);
            end
            step();
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL all_bubble%0d got valid=%0b exp 0", k, o_valid);
            end
        end
        step();
        step();
        checks++;
        if (o_valid !== 1'b0 || o_count !== 16'd8 || s_count !== 2'd3) begin
            failures++;
            $display("FAIL all_done got v=%0b c=%0d sat_c=%0d exp 0 8 3", o_valid, o_count, s_count);
        end
    endtask

    task automatic test_hold();
        do_reset();
        i_ready = 1'b0;
        drv[5] = 3'b001;
        step();
        step();
        checks++;
        if ({o_valid, o_lane, o_data} !== {1'b1, 3'd5, 3'b001}) begin
            failures++;
            $display("FAIL hold_first got v=%0b l=%0d d=%0b exp 1 5 001", o_valid, o_lane, o_data);
        end
        drv[5] = 3'b010;
        drv[2] = 3'b010;
        for (int n = 0; n < 4; n++) begin
            step();
            drv[2] = 3'b000;
            checks++;
            if ({o_valid, o_lane, o_data} !== {1'b1, 3'd5, 3'b001}) begin
                failures++;
                $display("FAIL hold_stable%0d got v=%0b l=%0d d=%0b exp 1 5 001", n, o_valid, o_lane, o_data);
            end
        end
        i_ready = 1'b1;
        step();
        step();
        checks++;
        if ({o_valid, o_lane, o_data} !== {1'b1, 3'd5, 3'b010}) begin
            failures++;
            $display("FAIL hold_followup got v=%0b l=%0d d=%0b exp 1 5 010", o_valid, o_lane, o_data);
        end
        step();
        step();
        step();
        checks++;
        if (o_valid !== 1'b0 || o_count !== 16'd2) begin
            failures++;
            $display("FAIL hold_no_lane2 got v=%0b c=%0d exp 0 2", o_valid, o_count);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        drv[6] = 3'b001;
        step();
        step();
        checks++;
        if ({o_valid, o_lane} !== {1'b1, 3'd6}) begin
            failures++;
            $display("FAIL rr_first got v=%0b l=%0d exp 1 6", o_valid, o_lane);
        end
        drv[1] = 3'b001;
        drv[7] = 3'b001;
        step();
        step();
        checks++;
        if ({o_valid, o_lane} !== {1'b1, 3'd7}) begin
            failures++;
            $display("FAIL rr_second got v=%0b l=%0d exp 1 7", o_valid, o_lane);
        end
        step();
        step();
        checks++;
        if ({o_valid, o_lane} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL rr_wrap got v=%0b l=%0d exp 1 1", o_valid, o_lane);
        end
    endtask

    task automatic test_enable();
        do_reset();
        i_en = 1'b0;
        drv[2] = 3'b011;
        step();
        step();
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL en_blocked got valid=%0b exp 0", o_valid);
        end
        i_en = 1'b1;
        i_ready = 1'b0;
        step();
        checks++;
        if ({o_valid, o_lane, o_data} !== {1'b1, 3'd2, 3'b011}) begin
            failures++;
            $display("FAIL en_grant got v=%0b l=%0d d=%0b exp 1 2 011", o_valid, o_lane, o_data);
        end
        i_en = 1'b0;
        drv[4] = 3'b001;
        step();
        checks++;
        if ({o_valid, o_lane} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL en_inflight got v=%0b l=%0d exp 1 2", o_valid, o_lane);
        end
        i_ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (o_valid !== 1'b0 || o_count !== 16'd1) begin
            failures++;
            $display("FAIL en_no_more got v=%0b c=%0d exp 0 1", o_valid, o_count);
        end
        i_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) drv[k] = 3'b001;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            step();
        end
        i_ready = 1'b0;
        step();
        checks++;
        if ({o_valid, o_lane, o_count} !== {1'b1, 3'd4, 16'd4}) begin
            failures++;
            $display("FAIL mid_present got v=%0b l=%0d c=%0d exp 1 4 4", o_valid, o_lane, o_count);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_lane, o_data, o_count} !== 23'd0) begin
            failures++;
            $display("FAIL mid_async_clear got v=%0b l=%0d d=%0b c=%0d exp all 0", o_valid, o_lane, o_data, o_count);
        end
        step();
        i_rst = 1'b0;
        i_ready = 1'b1;
        step();
        step();
        checks++;
        if ({o_valid, o_lane, o_data} !== {1'b1, 3'd0, 3'b001}) begin
            failures++;
            $display("FAIL mid_rereport0 got v=%0b l=%0d d=%0b exp 1 0 001", o_valid, o_lane, o_data);
        end
        step();
        step();
        checks++;
        if ({o_valid, o_lane, o_count} !== {1'b1, 3'd1, 16'd1}) begin
            failures++;
            $display("FAIL mid_rereport1 got v=%0b l=%0d c=%0d exp 1 1 1", o_valid, o_lane, o_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_lanes();
        test_hold();
        test_round_robin();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
